// File: rtl/a2d_rr_sched.sv
// Round-robin A2D scheduler: four sources share one SPI channel, two transactions per conversion.
// snd follows nxt by 1 cycle; nxt while busy collapses into one pending request (no stall upstream).
module a2d_rr_sched #(
  parameter int GAP_CYCLES = 2,
  parameter int TMO_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        snd,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] resp,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        upd,
  output logic [1:0]  upd_ch,
  output logic        busy,
  output logic        tmo_err
);

  localparam int TW = $clog2(TMO_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CMD, GAP, READ} state_t;

  state_t        state_q, state_d;
  logic [1:0]    rr_q, rr_d;
  logic          pend_q, pend_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          snd_d;
  logic [15:0]   cmd_d;
  logic          upd_d;
  logic [1:0]    upd_ch_d;
  logic          tmo_err_d;
  logic          wr_en;
  logic          done_ok;
  logic          tmo_hit;
  logic          conv_end;
  logic          unused_resp_hi;

  assign unused_resp_hi = ^resp[15:12];
  assign busy           = (state_q != IDLE);

  // rr index 0..3 maps to A2D channels 0,4,5,6
  function automatic logic [15:0] cmd_word(input logic [1:0] idx);
    logic [2:0] ch;
    ch = (idx == 2'd0) ? 3'd0 : 3'd3 + {1'b0, idx};
    return {2'b00, ch, 11'h000};
  endfunction

  // a done coincident with its own snd cannot be a real completion
  assign done_ok = done & ~snd;
  assign tmo_hit = (tmo_q == TMO_LAST) & ~done_ok;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    pend_d    = pend_q | (nxt & busy);
    tmo_d     = tmo_q + 1'b1;
    gap_d     = gap_q;
    snd_d     = 1'b0;
    cmd_d     = cmd;
    upd_d     = 1'b0;
    upd_ch_d  = upd_ch;
    tmo_err_d = tmo_err;
    wr_en     = 1'b0;
    conv_end  = 1'b0;

    case (state_q)
      IDLE: begin
        if (nxt) begin
          state_d = CMD;
          snd_d   = 1'b1;
          cmd_d   = cmd_word(rr_q);
          tmo_d   = '0;
        end
      end
      CMD: begin
        if (done_ok) begin
          state_d = GAP;
          gap_d   = '0;
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          rr_d      = rr_q + 2'd1;
          conv_end  = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = READ;
          snd_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      READ: begin
        if (done_ok) begin
          wr_en    = 1'b1;
          upd_d    = 1'b1;
          upd_ch_d = rr_q;
          rr_d     = rr_q + 2'd1;
          conv_end = 1'b1;
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          rr_d      = rr_q + 2'd1;
          conv_end  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // a queued (or coincident) request chains straight into the next command
    if (conv_end) begin
      pend_d = 1'b0;
      if (pend_q | nxt) begin
        state_d = CMD;
        snd_d   = 1'b1;
        cmd_d   = cmd_word(rr_d);
        tmo_d   = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= 2'd0;
      pend_q    <= 1'b0;
      tmo_q     <= '0;
      gap_q     <= '0;
      snd       <= 1'b0;
      cmd       <= 16'h0000;
      upd       <= 1'b0;
      upd_ch    <= 2'd0;
      tmo_err   <= 1'b0;
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      steer_pot <= 12'h000;
      batt      <= 12'h000;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      snd     <= snd_d;
      cmd     <= cmd_d;
      upd     <= upd_d;
      upd_ch  <= upd_ch_d;
      tmo_err <= tmo_err_d;
      if (wr_en) begin
        case (rr_q)
          2'd0:    lft_ld    <= resp[11:0];
          2'd1:    rght_ld   <= resp[11:0];
          2'd2:    steer_pot <= resp[11:0];
          default: batt      <= resp[11:0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Bench for a2d_rr_sched: reactive SPI model plus event logs checked against a channel/result model.
module tb_a2d_rr_sched;

  localparam int GAP = 2;
  localparam int TMO = 1024;

  typedef struct {
    int          dly;
    logic [15:0] rsp;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        nxt;
  logic        snd;
  logic [15:0] cmd;
  logic        done = 1'b0;
  logic [15:0] resp = 16'h0000;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        upd;
  logic [1:0]  upd_ch;
  logic        busy;
  logic        tmo_err;

  a2d_rr_sched #(.GAP_CYCLES(GAP), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .nxt(nxt), .snd(snd), .cmd(cmd), .done(done), .resp(resp),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .upd(upd), .upd_ch(upd_ch), .busy(busy), .tmo_err(tmo_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          model_rr = 0;
  logic [11:0] model_reg[4] = '{12'h0, 12'h0, 12'h0, 12'h0};
  logic        model_tmo = 1'b0;

  function automatic logic [15:0] exp_cmd(input int r);
    int chmap[4] = '{0, 4, 5, 6};
    return 16'(chmap[r % 4] * 2048);
  endfunction

  // SPI master model: one queued descriptor per snd; dly < 0 withholds done
  txn_t spi_q[$];
  int   spi_cnt = -1;
  logic [15:0] spi_rsp = 16'h0;
  int   stale_req = 0;
  int   stale_seen = 0;
  always @(negedge clk) begin
    txn_t t;
    done = 1'b0;
    if (stale_req != stale_seen) begin
      done = 1'b1;
      resp = 16'hFFF5;
      stale_seen = stale_req;
    end
    if (spi_cnt > 0) begin
      spi_cnt--;
      if (spi_cnt == 0) begin
        done = 1'b1;
        resp = spi_rsp;
        spi_cnt = -1;
      end
    end
    if (snd === 1'b1) begin
      if (spi_q.size() > 0) t = spi_q.pop_front();
      else begin
        t.dly = 40;
        t.rsp = 16'h0DEF;
      end
      spi_cnt = (t.dly > 0) ? t.dly : -1;
      spi_rsp = t.rsp;
    end
  end

  // event logs
  int          snd_cyc[$];
  logic [15:0] snd_cmd[$];
  int          upd_cyc[$];
  logic [1:0]  upd_chq[$];
  logic [11:0] upd_val[$];
  int   tmo_rise = -1;
  int   snd_consec = 0;
  int   busy_falls = 0;
  logic snd_prev = 1'b0, tmo_prev = 1'b0, busy_prev = 1'b0;

  function automatic logic [11:0] reg_of(input logic [1:0] c);
    case (c)
      2'd0:    return lft_ld;
      2'd1:    return rght_ld;
      2'd2:    return steer_pot;
      default: return batt;
    endcase
  endfunction

  always @(negedge clk) begin
    if (snd === 1'b1) begin
      snd_cyc.push_back(cyc);
      snd_cmd.push_back(cmd);
    end
    if (snd === 1'b1 && snd_prev === 1'b1) snd_consec++;
    if (upd === 1'b1) begin
      upd_cyc.push_back(cyc);
      upd_chq.push_back(upd_ch);
      upd_val.push_back(reg_of(upd_ch));
    end
    if (tmo_err === 1'b1 && tmo_prev !== 1'b1) tmo_rise = cyc;
    if (busy_prev === 1'b1 && busy === 1'b0) busy_falls++;
    snd_prev  = snd;
    tmo_prev  = tmo_err;
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    snd_cyc.delete(); snd_cmd.delete();
    upd_cyc.delete(); upd_chq.delete(); upd_val.delete();
    tmo_rise = -1;
    busy_falls = 0;
  endtask

  task automatic pad_logs(input int ns, input int nu);
    while (snd_cyc.size() < ns) begin snd_cyc.push_back(-1); snd_cmd.push_back(16'hFFFF); end
    while (upd_cyc.size() < nu) begin upd_cyc.push_back(-1); upd_chq.push_back(2'd3); upd_val.push_back(12'hFFF); end
  endtask

  task automatic push_txn(input int dly, input logic [15:0] rsp);
    txn_t t;
    t.dly = dly;
    t.rsp = rsp;
    spi_q.push_back(t);
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_lft"},   {20'h0, lft_ld},    {20'h0, model_reg[0]});
    chk({tag, "_rght"},  {20'h0, rght_ld},   {20'h0, model_reg[1]});
    chk({tag, "_steer"}, {20'h0, steer_pot}, {20'h0, model_reg[2]});
    chk({tag, "_batt"},  {20'h0, batt},      {20'h0, model_reg[3]});
    chk({tag, "_tmo"},   {31'h0, tmo_err},   {31'h0, model_tmo});
  endtask

  // one isolated conversion; d2 < 0 withholds the read completion
  task automatic conv_single(input logic [15:0] rsp, input int d1, input int d2);
    int nc, nsnd, nupd;
    logic [15:0] ec;
    clear_logs();
    push_txn(d1, 16'($urandom));
    push_txn(d2, rsp);
    ec = exp_cmd(model_rr);
    tick(); nxt = 1'b1; nc = cyc;
    tick(); nxt = 1'b0;
    for (int i = 0; i < d1 + GAP + TMO + 80 && busy === 1'b1; i++) tick();
    tick();
    chk("conv_idle", {31'h0, busy}, 32'h0);
    nsnd = snd_cyc.size();
    nupd = upd_cyc.size();
    pad_logs(2, 1);
    chk("snd_count", nsnd, 2);
    chk("snd_latency", snd_cyc[0], nc + 1);
    chk("cmd_first", {16'h0, snd_cmd[0]}, {16'h0, ec});
    chk("cmd_second", {16'h0, snd_cmd[1]}, {16'h0, ec});
    chk("gap_latency", snd_cyc[1], snd_cyc[0] + d1 + GAP + 1);
    if (d2 >= 0) begin
      chk("upd_count", nupd, 1);
      chk("upd_latency", upd_cyc[0], snd_cyc[1] + d2 + 1);
      chk("upd_ch", {30'h0, upd_chq[0]}, model_rr);
      chk("upd_val", {20'h0, upd_val[0]}, {20'h0, rsp[11:0]});
      model_reg[model_rr] = rsp[11:0];
    end else begin
      chk("upd_count_tmo", nupd, 0);
      chk("tmo_latency", tmo_rise, snd_cyc[1] + TMO);
      model_tmo = 1'b1;
    end
    model_rr = (model_rr + 1) % 4;
    chk_regs("conv");
  endtask

  initial begin
    logic [15:0] basic_rsp[4] = '{16'hF123, 16'h0456, 16'h0789, 16'h0ABC};
    int r0, nsnd, nupd, target;
    logic [15:0] ra, rb, rc;

    // reset
    rst = 1'b1; nxt = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_ctl", {28'h0, snd, upd, busy, tmo_err}, 32'h0);
    chk("rst_cmd", {14'h0, upd_ch, cmd}, 32'h0);
    chk_regs("rst");

    // basic sequence
    for (int k = 0; k < 4; k++) begin
      conv_single(basic_rsp[k], 40, 40);
      chk("basic_cmd", {16'h0, snd_cmd[0]}, {16'h0, exp_cmd(k)});
      repeat (100) tick();
    end
    chk("basic_lft", {20'h0, lft_ld}, 32'h123);
    chk("basic_rght", {20'h0, rght_ld}, 32'h456);
    chk("basic_steer", {20'h0, steer_pot}, 32'h789);
    chk("basic_batt", {20'h0, batt}, 32'hABC);

    // done while idle is ignored
    clear_logs();
    stale_req++;
    repeat (4) tick();
    chk("idle_done_upd", upd_cyc.size(), 0);
    chk_regs("idle_done");

    // wrap-around to channel 0
    conv_single(16'($urandom), 12, 17);
    chk("wrap_cmd", {16'h0, snd_cmd[0]}, 32'h0000);

    // randomized conversions
    for (int k = 0; k < 8; k++)
      conv_single(16'($urandom), $urandom_range(1, 60), $urandom_range(1, 60));

    // done exactly at the timeout terminal count
    conv_single(16'($urandom), 5, TMO - 1);

    // withheld read on channel index 1
    while (model_rr != 1) conv_single(16'($urandom), $urandom_range(1, 30), $urandom_range(1, 30));
    conv_single(16'h0FFF, 8, -1);
    conv_single(16'($urandom), 9, 11);
    chk("after_tmo_cmd", {16'h0, snd_cmd[0]}, 32'h2800);

    // pending collapse, then nxt coincident with conversion end
    clear_logs();
    r0 = model_rr;
    ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom);
    push_txn(25, 16'h1111); push_txn(30, ra);
    push_txn(20, 16'h2222); push_txn(35, rb);
    push_txn(15, 16'h3333); push_txn(20, rc);
    tick(); nxt = 1'b1;
    tick(); nxt = 1'b0;
    repeat (5) tick();
    for (int k = 0; k < 3; k++) begin
      nxt = 1'b1; tick();
      nxt = 1'b0; tick();
    end
    for (int i = 0; i < 400 && snd_cyc.size() < 4; i++) tick();
    target = (snd_cyc.size() >= 4) ? snd_cyc[3] + 35 : cyc;
    while (cyc < target) tick();
    nxt = 1'b1; tick();
    nxt = 1'b0;
    for (int i = 0; i < 600 && !(upd_cyc.size() >= 3 && busy === 1'b0); i++) tick();
    repeat (60) tick();
    nsnd = snd_cyc.size();
    nupd = upd_cyc.size();
    pad_logs(6, 3);
    chk("pend_snd_count", nsnd, 6);
    chk("pend_upd_count", nupd, 3);
    chk("pend_busy_falls", busy_falls, 1);
    chk("pend_b2b_1", snd_cyc[2], upd_cyc[0]);
    chk("pend_b2b_2", snd_cyc[4], upd_cyc[1]);
    chk("pend_gap", snd_cyc[1], snd_cyc[0] + 25 + GAP + 1);
    for (int k = 0; k < 3; k++) begin
      chk("pend_cmd", {16'h0, snd_cmd[2*k]}, {16'h0, exp_cmd(r0 + k)});
      chk("pend_upd_ch", {30'h0, upd_chq[k]}, (r0 + k) % 4);
    end
    chk("pend_val0", {20'h0, upd_val[0]}, {20'h0, ra[11:0]});
    chk("pend_val1", {20'h0, upd_val[1]}, {20'h0, rb[11:0]});
    chk("pend_val2", {20'h0, upd_val[2]}, {20'h0, rc[11:0]});
    model_reg[r0 % 4] = ra[11:0];
    model_reg[(r0 + 1) % 4] = rb[11:0];
    model_reg[(r0 + 2) % 4] = rc[11:0];
    model_rr = (r0 + 3) % 4;
    chk_regs("pend");

    // reset during the gap, then a stale done
    clear_logs();
    push_txn(30, 16'h4444); push_txn(40, 16'h0555);
    tick(); nxt = 1'b1;
    tick(); nxt = 1'b0;
    target = (snd_cyc.size() > 0) ? snd_cyc[0] + 31 : cyc;
    while (cyc < target) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    spi_q.delete();
    chk("mid_rst_ctl", {28'h0, snd, upd, busy, tmo_err}, 32'h0);
    chk("mid_rst_cmd", {14'h0, upd_ch, cmd}, 32'h0);
    model_rr = 0;
    model_reg = '{12'h0, 12'h0, 12'h0, 12'h0};
    model_tmo = 1'b0;
    chk_regs("mid_rst");
    clear_logs();
    @(posedge clk); #1;
    stale_req++;
    repeat (4) tick();
    chk("stale_upd", upd_cyc.size(), 0);
    chk("stale_busy", {31'h0, busy}, 32'h0);
    chk_regs("stale");
    conv_single(16'($urandom), 14, 22);
    chk("post_rst_cmd", {16'h0, snd_cmd[0]}, 32'h0000);

    chk("snd_never_consecutive", snd_consec, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/a2d_rr_sched.md
Name: a2d_rr_sched

Overview:
Round-robin A2D conversion scheduler that shares one SPI A2D channel between the four analog sources used by the segway: left load cell, right load cell, steering pot and battery. Each conversion is started by a `nxt` request and runs as two SPI transactions: a command, then a read. The block holds the latest 12-bit result for each source. Its `lft_ld`/`rght_ld` outputs feed the rider-detect/steer-enable logic, and `steer_pot`/`batt` feed the balance and battery paths.

Parameters:
GAP_CYCLES, 2, idle cycles between end of command transaction and start of read transaction (SS_n recovery)
TMO_CYCLES, 1024, max cycles waiting for `done` after a `snd` before abandoning the conversion

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous active-high reset
nxt  input  1  single-cycle request to convert the next channel in round-robin order
snd  output  1  single-cycle pulse to SPI master to start a transaction
cmd  output  16  SPI command word, valid whenever `snd`=1
done  input  1  single-cycle pulse from SPI master: transaction complete
resp  input  16  SPI response word, valid when `done`=1
lft_ld  output  12  latest left load-cell result
rght_ld  output  12  latest right load-cell result
steer_pot  output  12  latest steering-pot result
batt  output  12  latest battery result
upd  output  1  single-cycle pulse: one result register just updated
upd_ch  output  2  index of the register updated (0 lft, 1 rght, 2 steer, 3 batt), valid with `upd`
busy  output  1  conversion in progress
tmo_err  output  1  sticky: a transaction timed out

Behaviour:
- Reset (sync, active-high) clears all outputs to 0, `rr` pointer to 0, pending flag to 0, and the state to IDLE. This applies mid-transaction too; any `done` arriving afterwards is ignored.
- Channel map from `rr` to A2D channel: 0→ch0, 1→ch4, 2→ch5, 3→ch6.
- Command word is `{2'b00, ch[2:0], 11'h000}`. The same word is sent for both the command and read transactions. `cmd` is held stable from `snd` until the conversion ends.
- States are IDLE, CMD, GAP, READ.
- IDLE:
  - `nxt`=1 → on the next cycle `snd`=1 and `busy`=1, and the state moves to CMD.
  - Latency from `nxt` to `snd` is exactly 1 cycle.
- CMD:
  - Waits for `done`.
  - `done` → GAP, with the gap counter reset.
- GAP:
  - Counts GAP_CYCLES cycles.
  - After the last gap cycle, asserts `snd` for one cycle and moves to READ.
  - `done` is ignored here.
- READ:
  - `done` → on that edge, the selected register ← `resp[11:0]` and `rr` ← `rr`+1 (wraps 3→0).
  - `upd`=1 and `upd_ch`=old `rr` during the following cycle, which coincides with the new register value.
  - The state then returns to IDLE.
- Timeout:
  - In CMD or READ, a counter starts at 0 on the `snd` cycle and increments each cycle.
  - If it reaches TMO_CYCLES-1 without `done`, then `tmo_err` ← 1, the result register is unchanged, there is no `upd`, `rr` advances, and the state returns to IDLE.
  - `done` on the same cycle as the timeout terminal count wins: treated as normal completion.
- Pending request:
  - `nxt` while `busy` sets a pending flag; several such requests collapse into one.
  - At conversion end (normal or timeout), if pending is set, the pending flag is cleared, `snd` pulses on the next cycle and the state goes to CMD with the new `rr`. `busy` stays high with no gap.
  - `nxt` on the same cycle as conversion end also counts as pending.
- `busy`:
  - High from the cycle after `nxt` is accepted.
  - Low in the first IDLE cycle with nothing pending.
- `done` in IDLE is ignored.
- `tmo_err` clears only on `rst`.
- `snd` is never asserted for two consecutive cycles.

Test Plan:
- Basic sequence:
  - Stimulus: reset, then 4 `nxt` pulses spaced 200 cycles apart; SPI model returns `done` 40 cycles after each `snd`, with `resp`=16'hF123/0456/0789/0ABC.
  - Required response: cmds 16'h0000, 16'h2000, 16'h2800, 16'h3000, each sent twice; `lft_ld`=12'h123, `rght_ld`=12'h456, `steer_pot`=12'h789, `batt`=12'hABC; four `upd` pulses with `upd_ch` 0,1,2,3.
- Gap/latency:
  - Stimulus: a single `nxt`.
  - Required response: `snd` exactly 1 cycle after `nxt`; second `snd` exactly GAP_CYCLES+1 cycles after the first `done`; `upd` 1 cycle after the second `done`.
- Pending collapse:
  - Stimulus: 3 `nxt` pulses during one conversion.
  - Required response: exactly one extra conversion, back-to-back; `busy` never drops between them; `rr` advances by exactly 2 in total.
- Timeout:
  - Stimulus: SPI model withholds `done` on the read transaction for channel 1.
  - Required response: after TMO_CYCLES cycles, `tmo_err`=1, `rght_ld` keeps its old value, no `upd`, and the next `nxt` converts ch5 (cmd 16'h2800).
  - Boundary: `done` exactly at count TMO_CYCLES-1 updates normally with no error.
- Wrap-around:
  - Stimulus: 5 conversions.
  - Required response: the fifth uses cmd 16'h0000 and updates `lft_ld`.
- Reset mid-transaction:
  - Stimulus: assert `rst` in GAP, then deliver a stale `done`, then issue `nxt`.
  - Required response: all outputs 0, stale `done` ignored, next `nxt` starts at ch0.
